// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB round-robin arbiter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCAL  = 2'd1,
    BREQ   = 2'd2,
    BRIDGE = 2'd3
  } arb_state_e;

  // Slave-select bits that, when set, route the transfer through the APB bridge.
  localparam logic [3:0] ARB_BRIDGE_MASK_DEF = 4'b1100;

  // A transfer completes only on a ready beat without an error response.
  function automatic logic tr_done(input logic hready_out, input logic hresp);
    return hready_out & ~hresp;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner picker: first requester at or after ptr, wrapping around.
// With ptr tied to zero this degenerates to lowest-index-wins.
module arb_pick #(
  parameter int NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
  output logic                           valid,
  output logic [$clog2(NUM_MASTERS)-1:0] idx
);

  localparam int IW = $clog2(NUM_MASTERS);

  int cand;

  // Scan offsets from the far end down so the smallest offset from ptr is the
  // last assignment and therefore the winner.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_MASTERS;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter with local-slave grants and an APB-bridge request/grant
// handshake, including a bridge-grant timeout.
// Build option ARB_ROUND_ROBIN_EN: round-robin picking from a rotating pointer;
// when undefined, fixed priority (lowest index wins) and no pointer register.
//
// state  | meaning
// IDLE   | no owner; outputs cleared; picking a winner among requesters
// LOCAL  | winner owns a local slave; waiting for transfer completion
// BREQ   | winner targets the bridge; hreqb raised, waiting for hgrantb
// BRIDGE | bridge granted; winner owns the bus until transfer completion
module ahb_arbiter_rr
  import ahb_arb_pkg::*;
#(
  parameter int               NUM_MASTERS = 3,
  parameter int               SEL_W       = 4,
  parameter logic [SEL_W-1:0] BRIDGE_MASK = SEL_W'(ARB_BRIDGE_MASK_DEF),
  parameter int               BRIDGE_TO   = 15
) (
  input  logic                           hclk,
  input  logic                           hresetn,
  input  logic [NUM_MASTERS-1:0]         hreq,
  input  logic [NUM_MASTERS*SEL_W-1:0]   sel_in,
  input  logic                           hready_out,
  input  logic                           hresp,
  input  logic                           hgrantb,
  output logic                           hreqb,
  output logic [NUM_MASTERS-1:0]         hgrant,
  output logic [SEL_W-1:0]               sel,
  output logic [$clog2(NUM_MASTERS)-1:0] hmaster,
  output logic                           bto_err
);

  localparam int IW    = $clog2(NUM_MASTERS);
  localparam int CNT_W = (BRIDGE_TO > 1) ? $clog2(BRIDGE_TO) : 1;
  localparam bit TO_EN = (BRIDGE_TO > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = (BRIDGE_TO > 0) ? CNT_W'(BRIDGE_TO - 1) : '0;

  arb_state_e              state_q, state_d;
  logic [NUM_MASTERS-1:0]  hgrant_d;
  logic [SEL_W-1:0]        sel_d;
  logic [IW-1:0]           hmaster_d;
  logic                    hreqb_d;
  logic                    bto_err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic [IW-1:0]           pick_ptr;
  logic [SEL_W-1:0]        win_sel;
  logic                    xfer_done;

  assign xfer_done = tr_done(hready_out, hresp);
  assign win_sel   = sel_in[int'(pick_idx)*SEL_W +: SEL_W];

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;

  assign pick_ptr = ptr_q;

  // Advance past the owner only when its transfer completes; a timed-out
  // bridge request leaves the pointer alone so the same master keeps priority.
  always_comb begin
    ptr_d = ptr_q;
    if ((state_q == LOCAL || state_q == BRIDGE) && xfer_done) begin
      if (hmaster == IW'(NUM_MASTERS - 1)) ptr_d = '0;
      else                                 ptr_d = hmaster + IW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  assign pick_ptr = '0;
`endif

  arb_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .req   (hreq),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state and next-output logic; every path back to IDLE clears all outputs.
  always_comb begin
    state_d   = state_q;
    hgrant_d  = hgrant;
    sel_d     = sel;
    hmaster_d = hmaster;
    hreqb_d   = hreqb;
    bto_err_d = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        hgrant_d  = '0;
        sel_d     = '0;
        hmaster_d = '0;
        hreqb_d   = 1'b0;
        cnt_d     = '0;
        if (pick_valid) begin
          sel_d     = win_sel;
          hmaster_d = pick_idx;
          if ((win_sel & BRIDGE_MASK) == '0) begin
            state_d  = LOCAL;
            hgrant_d = NUM_MASTERS'(1) << pick_idx;
          end else begin
            state_d = BREQ;
            hreqb_d = 1'b1;
          end
        end
      end

      LOCAL: begin
        if (xfer_done) begin
          state_d   = IDLE;
          hgrant_d  = '0;
          sel_d     = '0;
          hmaster_d = '0;
        end
      end

      BREQ: begin
        if (hgrantb) begin
          state_d  = BRIDGE;
          hgrant_d = NUM_MASTERS'(1) << hmaster;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          hreqb_d   = 1'b0;
          sel_d     = '0;
          hmaster_d = '0;
          cnt_d     = '0;
          bto_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BRIDGE: begin
        if (xfer_done) begin
          state_d   = IDLE;
          hgrant_d  = '0;
          sel_d     = '0;
          hmaster_d = '0;
          hreqb_d   = 1'b0;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d   = IDLE;
        hgrant_d  = '0;
        sel_d     = '0;
        hmaster_d = '0;
        hreqb_d   = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State, wait counter and registered outputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      hgrant  <= '0;
      sel     <= '0;
      hmaster <= '0;
      hreqb   <= 1'b0;
      bto_err <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hgrant  <= hgrant_d;
      sel     <= sel_d;
      hmaster <= hmaster_d;
      hreqb   <= hreqb_d;
      bto_err <= bto_err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Self-checking bench for ahb_arbiter_rr; expectations come from a
// transaction-level model of the arbitration rules (picker + pointer).
module tb_ahb_arbiter_rr;

  localparam int N  = 3;
  localparam int SW = 4;
  localparam int TO = 15;
  localparam logic [SW-1:0] BMASK = 4'b1100;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            hclk = 1'b0;
  logic            hresetn;
  logic [N-1:0]    hreq;
  logic [N*SW-1:0] sel_in;
  logic            hready_out;
  logic            hresp;
  logic            hgrantb;
  logic            hreqb;
  logic [N-1:0]    hgrant;
  logic [SW-1:0]   sel;
  logic [1:0]      hmaster;
  logic            bto_err;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter_rr #(
    .NUM_MASTERS (N),
    .SEL_W       (SW),
    .BRIDGE_MASK (BMASK),
    .BRIDGE_TO   (TO)
  ) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .hreq       (hreq),
    .sel_in     (sel_in),
    .hready_out (hready_out),
    .hresp      (hresp),
    .hgrantb    (hgrantb),
    .hreqb      (hreqb),
    .hgrant     (hgrant),
    .sel        (sel),
    .hmaster    (hmaster),
    .bto_err    (bto_err)
  );

  // Reference rule: first requester at/after the pointer (round-robin) or lowest index.
  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    int start;
    start = RR ? ptr : 0;
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hreq = '0; hready_out = 1'b0; hresp = 1'b0; hgrantb = 1'b0;
    hresetn = 1'b0;
    step(); step();
    hresetn = 1'b1;
    step();
    m_ptr = 0;
  endtask

  // One complete ownership from IDLE: grant, optional bridge wait, hold with
  // error beats, completion. gdelay < 0 means hgrantb never arrives.
  task automatic do_txn(input logic [N-1:0] req, input logic [N*SW-1:0] sels,
                        input int hold, input int gdelay, input string tag);
    int w;
    logic [SW-1:0] ws;
    logic [N-1:0]  eg;
    bit br;
    hreq = req; sel_in = sels;
    w  = model_pick(req, m_ptr);
    ws = sels[w*SW +: SW];
    br = (ws & BMASK) != '0;
    eg = '0;
    if (!br) eg[w] = 1'b1;
    step();
    checks++;
    if (hmaster !== 2'(w) || sel !== ws)
      $display("FAIL %s owner: hmaster=%0d sel=%b, want hmaster=%0d sel=%b", tag, hmaster, sel, w, ws);
    checks++;
    if (hgrant !== eg || hreqb !== br || bto_err !== 1'b0)
      $display("FAIL %s grant: hgrant=%b hreqb=%b bto=%b, want hgrant=%b hreqb=%b bto=0", tag, hgrant, hreqb, bto_err, eg, br);
    if (hmaster !== 2'(w) || sel !== ws || hgrant !== eg || hreqb !== br || bto_err !== 1'b0) errors++;
    if (br) begin
      if (gdelay < 0) begin
        for (int k = 1; k < TO; k++) begin
          step();
          checks++;
          if (bto_err !== 1'b0 || hreqb !== 1'b1 || hgrant !== '0) begin
            errors++;
            $display("FAIL %s breq_wait c%0d: bto=%b hreqb=%b hgrant=%b, want 0 1 000", tag, k, bto_err, hreqb, hgrant);
          end
        end
        hreq = '0;
        step();
        checks++;
        if (bto_err !== 1'b1 || hreqb !== 1'b0 || hgrant !== '0 || hmaster !== 2'd0 || sel !== '0) begin
          errors++;
          $display("FAIL %s timeout: bto=%b hreqb=%b hgrant=%b hmaster=%0d sel=%b, want 1 0 000 0 0000", tag, bto_err, hreqb, hgrant, hmaster, sel);
        end
        step();
        checks++;
        if (bto_err !== 1'b0 || hreqb !== 1'b0 || hgrant !== '0) begin
          errors++;
          $display("FAIL %s bto_pulse: bto=%b hreqb=%b hgrant=%b, want 0 0 000", tag, bto_err, hreqb, hgrant);
        end
        return;
      end
      for (int k = 0; k < gdelay; k++) begin
        step();
        checks++;
        if (hreqb !== 1'b1 || hgrant !== '0 || bto_err !== 1'b0) begin
          errors++;
          $display("FAIL %s breq_hold c%0d: hreqb=%b hgrant=%b bto=%b, want 1 000 0", tag, k, hreqb, hgrant, bto_err);
        end
      end
      hgrantb = 1'b1;
      step();
      hgrantb = 1'b0;
      eg[w] = 1'b1;
      checks++;
      if (hgrant !== eg || hreqb !== 1'b1) begin
        errors++;
        $display("FAIL %s bridge_grant: hgrant=%b hreqb=%b, want %b 1", tag, hgrant, hreqb, eg);
      end
    end
    hreq = '0;
    for (int k = 0; k < hold; k++) begin
      hready_out = 1'($urandom_range(0, 1));
      hresp = 1'b1;
      step();
      checks++;
      if (hgrant !== eg || hreqb !== br || hmaster !== 2'(w) || bto_err !== 1'b0) begin
        errors++;
        $display("FAIL %s hold c%0d: hgrant=%b hreqb=%b hmaster=%0d, want %b %b %0d", tag, k, hgrant, hreqb, hmaster, eg, br, w);
      end
    end
    hready_out = 1'b1; hresp = 1'b0;
    step();
    hready_out = 1'b0;
    checks++;
    if (hgrant !== '0 || hreqb !== 1'b0 || hmaster !== 2'd0 || sel !== '0 || bto_err !== 1'b0) begin
      errors++;
      $display("FAIL %s release: hgrant=%b hreqb=%b hmaster=%0d sel=%b, want all zero", tag, hgrant, hreqb, hmaster, sel);
    end
    if (RR) m_ptr = (w + 1) % N;
  endtask

  task automatic test_reset();
    checks++;
    if (hgrant !== '0 || sel !== '0 || hmaster !== 2'd0 || hreqb !== 1'b0 || bto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: hgrant=%b sel=%b hmaster=%0d hreqb=%b bto=%b, want all zero", hgrant, sel, hmaster, hreqb, bto_err);
    end
  endtask

  task automatic test_single_local();
    do_txn(3'b010, {4'b0000, 4'b0001, 4'b0000}, 2, -1, "single_local");
  endtask

  task automatic test_rotation();
    int w;
    do_reset();
    hreq = 3'b111;
    sel_in = {4'b0011, 4'b0010, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      w = model_pick(hreq, m_ptr);
      step();
      checks++;
      if (hgrant !== 3'(1 << w) || hmaster !== 2'(w) || hreqb !== 1'b0) begin
        errors++;
        $display("FAIL rotation #%0d: hgrant=%b hmaster=%0d, want %b %0d", i, hgrant, hmaster, 3'(1 << w), w);
      end
      hready_out = 1'b1;
      step();
      hready_out = 1'b0;
      checks++;
      if (hgrant !== '0 || hmaster !== 2'd0) begin
        errors++;
        $display("FAIL rotation_gap #%0d: hgrant=%b hmaster=%0d, want 000 0", i, hgrant, hmaster);
      end
      if (RR) m_ptr = (w + 1) % N;
    end
    hreq = '0;
    step();
  endtask

  task automatic test_bridge_grant();
    do_txn(3'b100, {4'b0100, 4'b0001, 4'b0001}, 3, 4, "bridge_grant");
    do_txn(3'b100, {4'b1000, 4'b0001, 4'b0001}, 1, TO - 1, "bridge_late");
  endtask

  task automatic test_timeout();
    int w;
    logic [N*SW-1:0] s;
    logic [SW-1:0] ws;
    do_txn(3'b010, {4'b0000, 4'b0001, 4'b0000}, 0, -1, "timeout_pre");
    s = {4'b1000, 4'b0001, 4'b0010};
    hreq = 3'b100; sel_in = s;
    step();
    hreq = 3'b111;
    checks++;
    if (hreqb !== 1'b1 || hgrant !== '0 || hmaster !== 2'd2) begin
      errors++;
      $display("FAIL timeout_entry: hreqb=%b hgrant=%b hmaster=%0d, want 1 000 2", hreqb, hgrant, hmaster);
    end
    for (int k = 1; k < TO; k++) begin
      step();
      checks++;
      if (bto_err !== 1'b0 || hreqb !== 1'b1) begin
        errors++;
        $display("FAIL timeout_wait c%0d: bto=%b hreqb=%b, want 0 1", k, bto_err, hreqb);
      end
    end
    step();
    checks++;
    if (bto_err !== 1'b1 || hreqb !== 1'b0 || hgrant !== '0 || hmaster !== 2'd0) begin
      errors++;
      $display("FAIL timeout_pulse: bto=%b hreqb=%b hgrant=%b hmaster=%0d, want 1 0 000 0", bto_err, hreqb, hgrant, hmaster);
    end
    w  = model_pick(3'b111, m_ptr);
    ws = s[w*SW +: SW];
    step();
    hreq = '0;
    checks++;
    if (bto_err !== 1'b0 || hmaster !== 2'(w) || hreqb !== ((ws & BMASK) != '0)) begin
      errors++;
      $display("FAIL timeout_regrant: bto=%b hmaster=%0d hreqb=%b, want 0 %0d %b", bto_err, hmaster, hreqb, w, (ws & BMASK) != '0);
    end
    if ((ws & BMASK) != '0) begin
      hgrantb = 1'b1;
      step();
      hgrantb = 1'b0;
    end
    checks++;
    if (hgrant !== 3'(1 << w)) begin
      errors++;
      $display("FAIL timeout_regrant_grant: hgrant=%b, want %b", hgrant, 3'(1 << w));
    end
    hready_out = 1'b1;
    step();
    hready_out = 1'b0;
    if (RR) m_ptr = (w + 1) % N;
  endtask

  task automatic test_reset_mid_grant();
    int w;
    hreq = 3'b001; sel_in = {4'b0000, 4'b0000, 4'b0001};
    w = model_pick(hreq, m_ptr);
    step();
    checks++;
    if (hgrant !== 3'(1 << w)) begin
      errors++;
      $display("FAIL reset_mid_pre: hgrant=%b, want %b", hgrant, 3'(1 << w));
    end
    #2 hresetn = 1'b0;
    #1;
    checks++;
    if (hgrant !== '0 || sel !== '0 || hmaster !== 2'd0 || hreqb !== 1'b0 || bto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: hgrant=%b sel=%b hmaster=%0d hreqb=%b, want all zero", hgrant, sel, hmaster, hreqb);
    end
    hreq = '0;
    step();
    hresetn = 1'b1;
    step();
    m_ptr = 0;
  endtask

  task automatic test_random();
    logic [N-1:0]    r;
    logic [N*SW-1:0] s;
    int gd;
    for (int i = 0; i < 30; i++) begin
      r  = 3'($urandom_range(1, 7));
      s  = 12'($urandom);
      gd = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      do_txn(r, s, int'($urandom_range(0, 4)), gd, "random");
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_local();
    test_rotation();
    test_bridge_grant();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_rr.md
# ahb_arbiter_rr

Parametrised AHB bus arbiter granting one of NUM_MASTERS requesters to the shared address/write-data muxes, with local-slave grants and a request/grant handshake toward the AHB-to-APB bridge. It sits between the masters and the slave-select/mux logic of the AHB fabric. Compared with the previous arbiter, it adds N-master scaling, round-robin fairness, and per-winner bridge detection. It also adds a bridge-grant timeout with an error pulse.

## Interface
Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8)
- SEL_W, 4, width of each master's slave-select vector
- BRIDGE_MASK, 4'b1100, sel bits that route to the bridge; any set bit in (sel & BRIDGE_MASK) means bridge target
- BRIDGE_TO, 15, cycles to wait for hgrantb before abandoning; 0 disables the timeout

Ports:
- hclk  in  1  clock
- hresetn  in  1  reset; asynchronous, active-low
- hreq  in  NUM_MASTERS  per-master bus request
- sel_in  in  NUM_MASTERS*SEL_W  packed slave selects, master i at [i*SEL_W +: SEL_W]
- hready_out  in  1  ready from selected slave
- hresp  in  1  error response from selected slave
- hgrantb  in  1  grant returned by bridge
- hreqb  out  1  request to bridge
- hgrant  out  NUM_MASTERS  one-hot grant, all zero when idle
- sel  out  SEL_W  captured select of granted master
- hmaster  out  $clog2(NUM_MASTERS)  index of current owner, 0 when idle
- bto_err  out  1  one-cycle pulse on bridge timeout

## Operation
- tr_done = hready_out & ~hresp.
- States: IDLE, LOCAL, BREQ, BRIDGE. All outputs are registered.
- IDLE: if any hreq, the picker selects winner w. On the next edge, sel <= sel_in[w] and hmaster <= w. sel and hmaster are held stable until return to IDLE.
  - If (sel_in[w] & BRIDGE_MASK) == 0: go to LOCAL with hgrant[w] = 1.
  - Otherwise: go to BREQ with hreqb = 1 and hgrant = 0.
- LOCAL: hold until tr_done, then go to IDLE.
- BREQ: when hgrantb = 1, go to BRIDGE with hgrant[w] = 1 and hreqb kept at 1. The wait counter increments each BREQ cycle. If it reaches BRIDGE_TO (BRIDGE_TO > 0), go to IDLE, drop hreqb, and pulse bto_err.
- BRIDGE: hold until tr_done, then go to IDLE and drop hreqb. A deassertion of hgrantb inside BRIDGE is ignored.
- Ownership rules:
  - Deasserting hreq mid-transfer does not revoke a grant; only tr_done or timeout ends ownership.
  - hresp = 1 with hready_out = 1 is not done; the grant is held.
- Entering IDLE clears hgrant, sel, hmaster, hreqb, and the wait counter.
- Round-robin pointer: after granting w, ptr <= (w+1) mod NUM_MASTERS. The pointer is not updated on a timeout-abandoned grant, so w keeps priority.

## Timing
- Reset (async assert, sync release): state = IDLE; hgrant = 0, sel = 0, hmaster = 0, hreqb = 0, bto_err = 0, ptr = 0, counter = 0.
- Request sampled at edge t produces the grant (or hreqb) visible after edge t+1. Latency is 1 cycle.
- tr_done at edge t makes outputs idle after t+1. The earliest regrant is visible after t+2: one mandatory idle cycle between owners.
- Bridge path: hgrantb sampled high at edge t makes hgrant[w] visible after t+1.
- Timeout: with BRIDGE_TO = K, bto_err is high for exactly one cycle, K cycles after BREQ entry. Outputs are idle in the same cycle.
- Simultaneous requests are resolved in a single cycle; no combinational path runs from hreq to any output.

## Configuration
- ARB_ROUND_ROBIN_EN defined: the picker starts searching at ptr and wraps around, choosing the first requester at or after ptr.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, where the lowest index wins. The ptr register is removed, and other behaviour is identical.

## Structure
- Package ahb_arb_pkg: state enum (IDLE/LOCAL/BREQ/BRIDGE), default BRIDGE_MASK constant, and the tr_done helper function.
- Sub-module arb_pick: combinational request vector plus pointer in, giving a valid flag and winner index out. Parametrised by NUM_MASTERS and instantiated once.
- The top level holds the FSM, timeout counter, pointer, and output registers.

## Test plan
- Single master 1, sel = 4'b0001, tr_done after 3 cycles: hgrant = 3'b010 one cycle after hreq, sel = 1, then grant drops after tr_done. hreqb is never asserted.
- hreq = 3'b111 held continuously with local targets (round-robin enabled): grants rotate 0,1,2,0, with one idle cycle between owners.
- Same stimulus with the macro undefined: master 0 is granted every time.
- Master 2 with sel = 4'b0100: hreqb = 1 and hgrant = 0. hgrantb is raised 4 cycles later, giving hgrant[2] = 1 on the next cycle. tr_done clears hreqb.
- Bridge target with hgrantb never asserted and BRIDGE_TO = 15: bto_err pulses once after 15 BREQ cycles, outputs go idle, and master 2 is regranted first.
- hresp = 1 with hready_out = 1 mid-grant: the grant is held. hresetn pulsed low mid-grant: all outputs are 0 immediately.
